// File: rtl/dmem_responder_if.sv
// Data-port handshake between the core datapath (master) and the memory responder (slave).
// The request fields are sampled only while the responder is idle; the response fields are all registered.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM plus LED/switch/timer MMIO behind a req/ready port; ready pulses WAIT_CYCLES+1 cycles after acceptance.
// There is no backpressure: the request is ignored while busy, and a new request is accepted only in IDLE.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_responder_if.slave   bus,
  input  logic [7:0]        sw,
  output logic [7:0]        leds
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic err;
    logic ram;
    logic led;
    logic swi;
    logic tmr;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] a, input logic w);
    dec_t d;
    d     = '0;
    d.ram = (a < RAM_BYTES);
    d.led = (a == MMIO_BASE);
    d.swi = (a == MMIO_BASE + 32'd4);
    d.tmr = (a == MMIO_BASE + 32'd8);
    d.err = (a[1:0] != 2'b00) || !(d.ram || d.led || d.swi || d.tmr) || (w && d.swi);
    return d;
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [AW-1:0]   ram_idx_q;
  logic [31:0]     wdata_q;
  dec_t            dec_q;

  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [7:0]      leds_q, leds_d;
  logic [31:0]     timer_q, timer_d;
  logic [7:0]      sw_meta_q, sw_sync_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            accept;
  logic            enter_resp;
  logic            commit;
  logic            src_we;
  logic [AW-1:0]   src_idx;
  dec_t            dec_in, src_dec;
  logic [31:0]     load_val;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      ram_idx_q <= '0;
      wdata_q   <= '0;
      dec_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      leds_q    <= '0;
      timer_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      leds_q    <= leds_d;
      timer_q   <= timer_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      if (accept) begin
        we_q      <= bus.we;
        ram_idx_q <= bus.addr[AW+1:2];
        wdata_q   <= bus.wdata;
        dec_q     <= dec_in;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. With zero wait states RESP is entered on the
  // accepting edge, so the response is built from the live request fields then.
  always_comb begin
    accept     = (state_q == S_IDLE) && bus.req;
    dec_in     = decode(bus.addr, bus.we);
    src_dec    = (state_q == S_IDLE) ? dec_in : dec_q;
    src_we     = (state_q == S_IDLE) ? bus.we : we_q;
    src_idx    = (state_q == S_IDLE) ? bus.addr[AW+1:2] : ram_idx_q;
    enter_resp = (state_d == S_RESP);
    commit     = (state_q == S_RESP) && we_q && !dec_q.err;

    load_val = '0;
    if (src_dec.ram) begin
      load_val = mem_q[src_idx];
    end else if (src_dec.led) begin
      load_val = {24'd0, leds_q};
    end else if (src_dec.swi) begin
      load_val = {24'd0, sw_sync_q};
    end else if (src_dec.tmr) begin
      load_val = timer_q;
    end

    ready_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
    err_d   = enter_resp && src_dec.err;
    rdata_d = rdata_q;
    if (enter_resp) begin
      rdata_d = (src_we || src_dec.err) ? 32'd0 : load_val;
    end

    leds_d = leds_q;
    if (commit && dec_q.led) begin
      leds_d = wdata_q[7:0];
    end

    // A timer store overrides that cycle's increment
    timer_d = timer_q + 32'd1;
    if (commit && dec_q.tmr) begin
      timer_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && dec_q.ram) begin
      mem_q[ram_idx_q] <= wdata_q;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign leds      = leds_q;

  a_ready_pulse: assert property (@(posedge clk) disable iff (!reset_n) ready_q |=> !ready_q);
  a_err_only_with_ready: assert property (@(posedge clk) disable iff (!reset_n) err_q |-> ready_q);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a WAIT_CYCLES=1 responder for RAM/MMIO/timer/error/reset scenarios
// and a WAIT_CYCLES=0 responder for held back-to-back requests.
module tb_dmem_responder;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic [7:0] leds1, leds0;
  int         n_checks;
  int         n_fail;

  dmem_responder_if bus1();
  dmem_responder_if bus0();

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1), .MMIO_BASE(32'h0000_1000)) u_dut1 (
    .clk(clk), .reset_n(rst_n), .bus(bus1), .sw(sw), .leds(leds1)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .MMIO_BASE(32'h0000_1000)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .bus(bus0), .sw(sw), .leds(leds0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Issue one request on bus1 from a negedge; returns at the negedge where ready is seen.
  task automatic txn1(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat);
    bus1.req = 1'b1; bus1.we = w; bus1.addr = a; bus1.wdata = d;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    lat = -1; rd = 32'hxxxx_xxxx; e = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus1.ready === 1'b1) begin
        lat = k; rd = bus1.rdata; e = bus1.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic e; int lat;
    n_checks++; if (bus1.rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata got %h want %h", bus1.rdata, 32'd0); end
    n_checks++; if (bus1.ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", bus1.ready); end
    n_checks++; if (bus1.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", bus1.err); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus1.busy); end
    n_checks++; if (leds1 !== 8'h00) begin n_fail++; $display("FAIL rst_leds got %h want 00", leds1); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy0 got %b want 0", bus0.busy); end
    rst_n = 1'b1;
    // Timer is 0 at release; first edge accepts (timer->1), second edge enters RESP sampling 1
    txn1(1'b0, 32'h0000_1008, 32'd0, rd, e, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rst_timer_lat got %0d want 2", lat); end
    n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL rst_timer_val got %h want %h", rd, 32'd1); end
    @(negedge clk);
  endtask

  task automatic test_ram();
    logic [31:0] rd; logic e; int lat;
    txn1(1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL st_lat got %0d want 2", lat); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL st_err got %b want 0", e); end
    n_checks++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL st_busy_resp got %b want 1", bus1.busy); end
    @(negedge clk);
    n_checks++; if (bus1.ready !== 1'b0) begin n_fail++; $display("FAIL st_ready_pulse got %b want 0", bus1.ready); end
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL st_busy_idle got %b want 0", bus1.busy); end
    txn1(1'b0, 32'h10, 32'd0, rd, e, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ld_lat got %0d want 2", lat); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b want 0", e); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_rdata got %h want %h", rd, 32'hDEAD_BEEF); end
    @(negedge clk);
    n_checks++; if (bus1.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_rdata_hold got %h want %h", bus1.rdata, 32'hDEAD_BEEF); end
    txn1(1'b1, 32'h20, 32'h1234_5678, rd, e, lat);
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL st_rdata_zero got %h want %h", rd, 32'd0); end
    @(negedge clk);
  endtask

  task automatic test_mmio();
    logic [31:0] rd; logic e; int lat;
    txn1(1'b1, 32'h0000_1000, 32'hFFFF_FFA5, rd, e, lat);
    n_checks++; if (leds1 !== 8'h00) begin n_fail++; $display("FAIL led_before got %h want 00", leds1); end
    @(negedge clk);
    n_checks++; if (leds1 !== 8'hA5) begin n_fail++; $display("FAIL led_after got %h want a5", leds1); end
    sw = 8'h3C;
    repeat (3) @(negedge clk);
    txn1(1'b0, 32'h0000_1004, 32'd0, rd, e, lat);
    n_checks++; if (rd !== 32'h0000_003C) begin n_fail++; $display("FAIL sw_load got %h want %h", rd, 32'h3C); end
    @(negedge clk);
    txn1(1'b0, 32'h0000_1000, 32'd0, rd, e, lat);
    n_checks++; if (rd !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_load got %h want %h", rd, 32'hA5); end
    @(negedge clk);
    txn1(1'b1, 32'h0000_1004, 32'h0000_0011, rd, e, lat);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL sw_store_err got %b want 1", e); end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sw_store_rdata got %h want 0", rd); end
    @(negedge clk);
    txn1(1'b0, 32'h0000_1004, 32'd0, rd, e, lat);
    n_checks++; if (rd !== 32'h0000_003C) begin n_fail++; $display("FAIL sw_after_store got %h want %h", rd, 32'h3C); end
    n_checks++; if (leds1 !== 8'hA5) begin n_fail++; $display("FAIL led_untouched got %h want a5", leds1); end
    @(negedge clk);
  endtask

  task automatic test_timer();
    logic [31:0] rd; logic e; int lat;
    txn1(1'b1, 32'h0000_1008, 32'hFFFF_FFFE, rd, e, lat);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL tmr_store_err got %b want 0", e); end
    @(negedge clk);
    // Store edge loads FFFFFFFE; 5 idle edges + accept edge precede the RESP-entry sample: 6 increments
    repeat (5) @(negedge clk);
    txn1(1'b0, 32'h0000_1008, 32'd0, rd, e, lat);
    n_checks++; if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL tmr_wrap got %h want %h", rd, 32'h4); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    txn1(1'b1, 32'h0, 32'h1111_1111, rd, e, lat); @(negedge clk);
    txn1(1'b1, 32'h800, 32'hFFFF_FFFF, rd, e, lat);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL st800_err got %b want 1", e); end
    @(negedge clk);
    txn1(1'b0, 32'h0, 32'd0, rd, e, lat);
    n_checks++; if (rd !== 32'h1111_1111) begin n_fail++; $display("FAIL st800_noram got %h want %h", rd, 32'h1111_1111); end
    @(negedge clk);
    txn1(1'b0, 32'h12, 32'd0, rd, e, lat);
    n_checks++; if (lat !== 2 || e !== 1'b1) begin n_fail++; $display("FAIL ld12_err got lat %0d err %b want lat 2 err 1", lat, e); end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ld12_rdata got %h want 0", rd); end
    @(negedge clk);
    txn1(1'b0, 32'h800, 32'd0, rd, e, lat);
    n_checks++; if (e !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL ld800 got err %b rdata %h want err 1 rdata 0", e, rd); end
    @(negedge clk);
    txn1(1'b0, 32'h100, 32'd0, rd, e, lat);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL ld100_err got %b want 1", e); end
    @(negedge clk);
    txn1(1'b1, 32'hFC, 32'hCAFE_F00D, rd, e, lat);
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL stFC_err got %b want 0", e); end
    @(negedge clk);
    txn1(1'b0, 32'hFC, 32'd0, rd, e, lat);
    n_checks++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ldFC got %h want %h", rd, 32'hCAFE_F00D); end
    @(negedge clk);
    txn1(1'b0, 32'h0000_100C, 32'd0, rd, e, lat);
    n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL ld100C_err got %b want 1", e); end
    n_checks++; if (leds1 !== 8'hA5) begin n_fail++; $display("FAIL err_leds got %h want a5", leds1); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat; int seen;
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 32'h20; bus1.wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_wait got %b want 1", bus1.busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus1.busy); end
    n_checks++; if (leds1 !== 8'h00) begin n_fail++; $display("FAIL abort_leds got %h want 00", leds1); end
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus1.ready !== 1'b0) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_ready got %0d pulses want 0", seen); end
    rst_n = 1'b1;
    txn1(1'b0, 32'h20, 32'd0, rd, e, lat);
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL abort_ram got %h want %h", rd, 32'h1234_5678); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h40; bus0.wdata = 32'h55;
    @(negedge clk);
    n_checks++; if (bus0.ready !== 1'b1 || bus0.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_resp1 got ready %b busy %b want 1 1", bus0.ready, bus0.busy); end
    bus0.wdata = 32'h99;
    @(negedge clk);
    n_checks++; if (bus0.ready !== 1'b0 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle1 got ready %b busy %b want 0 0", bus0.ready, bus0.busy); end
    bus0.we = 1'b0;
    @(negedge clk);
    n_checks++; if (bus0.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resp2 got ready %b want 1", bus0.ready); end
    n_checks++; if (bus0.rdata !== 32'h55) begin n_fail++; $display("FAIL b2b_rdata2 got %h want %h", bus0.rdata, 32'h55); end
    @(negedge clk);
    n_checks++; if (bus0.ready !== 1'b0 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle2 got ready %b busy %b want 0 0", bus0.ready, bus0.busy); end
    @(negedge clk);
    n_checks++; if (bus0.ready !== 1'b1 || bus0.rdata !== 32'h55) begin n_fail++; $display("FAIL b2b_resp3 got ready %b rdata %h want 1 55", bus0.ready, bus0.rdata); end
    bus0.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus0.ready !== 1'b0 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_quiet got ready %b busy %b want 0 0", bus0.ready, bus0.busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sw       = 8'h00;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_ram();
    test_mmio();
    test_timer();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the core's data port. It services word load/store requests from the datapath: the datapath supplies address (ALUResult), store data (WriteData) and a write strobe, and this block returns load data (ReadData). It holds a word-addressed data RAM plus three memory-mapped registers: LEDs, switches and a free-running timer. A req/ready handshake with configurable wait states prepares the port for a multicycle core.

Parameters:
DEPTH_WORDS, 64, number of 32-bit RAM words; power of two, 4..4096
WAIT_CYCLES, 1, extra cycles inserted between acceptance and response; 0..15
MMIO_BASE, 32'h0000_1000, base byte address of the MMIO window; must lie above the RAM range

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  1  request strobe; sampled only in IDLE
we  input  1  1 = store, 0 = load; sampled with req
addr  input  32  byte address; sampled with req
wdata  input  32  store data; sampled with req
rdata  output  32  load data; valid while ready=1, held afterwards
ready  output  1  one-cycle response pulse
err  output  1  error flag; valid while ready=1
busy  output  1  1 in every state except IDLE
sw  input  8  external switches, asynchronous
leds  output  8  LED register

Behaviour:
- Reset (async assert, sync release): state=IDLE; rdata=0, ready=0, err=0, busy=0, leds=0, timer=0, sw sync flops=0. RAM contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE, req=1: latch we/addr/wdata. Go to WAIT and load the counter with WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise go directly to RESP.
  - WAIT: decrement the counter. When the counter is 0, go to RESP.
  - RESP: ready=1 for exactly one cycle, then go to IDLE unconditionally.
  - req in WAIT or RESP is ignored. A new request is accepted no earlier than the IDLE cycle after RESP.
- Latency: request accepted at cycle 0 gives ready=1 in cycle WAIT_CYCLES+1.
- Decode uses the latched addr:
  - addr[1:0]!=0: misaligned, err=1.
  - addr < 4*DEPTH_WORDS: RAM word addr[log2(DEPTH_WORDS)+1:2].
  - MMIO_BASE+0x0: LEDs, read/write; reads return leds zero-extended, writes take wdata[7:0].
  - MMIO_BASE+0x4: switches, read-only; reads return the 2-flop-synchronized sw, zero-extended; a write is an error.
  - MMIO_BASE+0x8: timer, read/write.
  - Any other address: err=1.
- Errors: err=1 with ready; rdata=0; no state change anywhere.
- Loads: rdata is registered on the edge entering RESP. It holds that value until the next load response. A store response drives rdata=0.
- Stores: the target is updated on the edge leaving RESP, so a following load always sees the stored value.
- Timer: 32-bit, increments every cycle including during reset release; wraps 0xFFFF_FFFF -> 0. A store to the timer loads wdata and takes priority over the increment that cycle. A timer load returns the value present at the edge entering RESP.
- Reset asserted mid-transaction aborts it: no write, no ready pulse, FSM returns to IDLE.
- err, ready and rdata use no combinational path from the request inputs. All outputs are registered.

Test Plan:
- WAIT_CYCLES=1: store 0xDEADBEEF to 0x10, then load 0x10 -> each ready is high exactly at cycle 2 after acceptance, err=0, load rdata=0xDEADBEEF.
- WAIT_CYCLES=0: back-to-back requests held high -> ready at cycle 1, next acceptance in the IDLE cycle after RESP; requests asserted during RESP are ignored (busy=1).
- Store 0xA5 to MMIO_BASE+0x0 -> leds=0xA5 after RESP. Set sw=0x3C and wait >=2 cycles, load MMIO_BASE+0x4 -> rdata=0x0000_003C. Store to MMIO_BASE+0x4 -> err=1, no change.
- Store 0xFFFF_FFFE to the timer, then load after a known gap -> value equals the load value plus elapsed cycles mod 2^32, showing wrap through 0.
- Load 0x12 (misaligned) and 0x800 (unmapped) -> ready with err=1, rdata=0. Store to 0x800 -> no RAM or MMIO change.
- Accept a store to 0x20 and assert reset_n=0 during WAIT -> no ready, busy=0, leds=0. Re-load 0x20 after a prior known write -> old value retained.
